window_sum: RTL and testbench
=============================

Name: window_sum

Overview:
Downstream consumer stage for generator modules such as hrange/dup_range_goal. It takes one signed 32-bit stream through a ready/valid/done input port and produces a generator-style output stream. Each output is the sliding-window sum over the last `window` items, plus the index of the newest item. It behaves like the Python generator `for k, x in enumerate(src): buf.append(x); buf = buf[-window:]; if len(buf) == window: yield sum(buf), k`, with 32-bit wrap-around arithmetic.

Parameters:
MAX_WIDTH, 8, maximum window length; sizes the internal circular buffer (any value >= 1).
PTR_W, $clog2(MAX_WIDTH) (min 1), width of the buffer write pointer and fill counter.

Ports:
_clock  input  1  sole clock; all state updates on posedge.
_reset  input  1  synchronous, active-high reset; moves the block to the done state.
_start  input  1  capture `window` and start consuming; takes precedence over _reset in the same cycle.
window  input  32 signed  window length; sampled only when _start is high.
_in0  input  32 signed  upstream data.
_in_valid  input  1  upstream data valid.
_in_done  input  1  upstream generator finished.
_in_ready  output  1  combinational; this block accepts _in0 this cycle.
_ready  input  1  downstream ready for output.
_valid  output  1  registered; _out0/_out1 valid.
_done  output  1  registered; block finished.
_out0  output  32 signed  window sum.
_out1  output  32 signed  0-based index of the newest item in the window.

Behaviour:
- States: _state_pull and _state_done.
- Reset (_reset high, _start low):
  - Next cycle: _state = _state_done, _valid = 0, _done = 0, _out0 = _out1 = 0.
  - Fill, write pointer, sum and index all clear.
  - From the following cycle, _done is high in every cycle spent in _state_done.
- Default per cycle: _done <= 0; if _ready then _valid <= 0.
- _start (any state, including mid-operation and with _reset high):
  - Latch the window: w = MAX_WIDTH if window > MAX_WIDTH, else window.
  - Clear fill, pointer, sum and index. Drop any pending output: _valid <= 0.
  - If window <= 0: _done <= 1 and go to _state_done, with no outputs.
  - Otherwise go to _state_pull.
  - No item is accepted in the _start cycle.
- _in_ready = (_state == _state_pull) && (_ready || !_valid) && !_in_done && !_start. It is low in _state_done.
- Accept occurs when _in_valid && _in_ready. On accept of x:
  - If fill < w: buf[ptr] <= x, sum <= sum + x, fill++.
  - Otherwise: sum <= sum + x - buf[ptr], buf[ptr] <= x.
  - ptr <= (ptr == w-1) ? 0 : ptr + 1; idx <= idx + 1.
  - If the post-accept fill equals w: _out0 <= new sum, _out1 <= idx (pre-increment value), _valid <= 1.
- Latency: item accepted in cycle N gives _valid high in cycle N+1. Throughput is 1 item/cycle while _ready is high.
- Backpressure: while _valid && !_ready, _in_ready is low and _out0/_out1/_valid are held stable.
- Termination (_state_pull):
  - If _in_done is high and (_ready || !_valid): _done <= 1, go to _state_done.
  - Any _in0/_in_valid in that cycle is ignored (done has priority over data, matching generator convention).
  - A pending output is always consumed before _done rises. If _ready and _valid are high in the termination cycle, _valid falls and _done rises in the same next cycle.
- Arithmetic: all sums are 32-bit two's complement with silent wrap, no saturation. The index also wraps at 2^32.
- Buffer contents are not reset; only fill gates their use.

Test Plan:
- window=3; upstream yields 0,2,4,6,8 then done; _ready=1 -> outputs (6,2), (12,3), (18,4) on consecutive cycles, then _done high; no other _valid pulses.
- window=1; stream 5,-3,7 -> outputs (5,0), (-3,1), (7,2); the sums equal the items.
- window=0 -> _done high the cycle after _start; _valid never high; _in_ready stays 0. Separately, window=20 with MAX_WIDTH=8 and a 5-item stream -> no outputs, then done.
- window=2; stream 0x7FFFFFFF, 1 -> _out0 = -2147483648 (wrap), _out1 = 1.
- Backpressure: window=2, stream 1,2,3,4; hold _ready low for 3 cycles after the first _valid -> _in_ready=0 and (3,1) held for those cycles; all outputs (3,1), (5,2), (7,3) delivered in order, none lost.
- _reset mid-stream after the first output -> _valid=0 next cycle, then _done high. _start and _reset high together with window=2 and stream 10,20 -> fresh output (30,1), with no carry-over from the prior run.

Source files
------------

// File: rtl/window_sum.sv
// window_sum: sliding-window sum over a ready/valid/done input stream.
// Each output carries the wrapped 32-bit sum of the newest `window` items
// and the 0-based index of the newest item in that window.
module window_sum #(
    parameter int MAX_WIDTH = 8,
    parameter int PTR_W     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic signed [31:0] window,
    input  logic signed [31:0] _in0,
    input  logic               _in_valid,
    input  logic               _in_done,
    output logic               _in_ready,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _out0,
    output logic signed [31:0] _out1
);

    // Fill counter and latched window need one extra bit to hold MAX_WIDTH itself.
    localparam int                 CNT_W  = PTR_W + 1;
    localparam logic signed [31:0] MaxWin = MAX_WIDTH;
    localparam logic [CNT_W-1:0]   CntOne = 1;
    localparam logic [PTR_W-1:0]   PtrOne = 1;

    typedef enum logic {
        StPull,
        StDone
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_term;

    logic [CNT_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_fill;
    logic [PTR_W-1:0]   r_ptr;
    logic signed [31:0] r_sum;
    logic signed [31:0] r_idx;
    logic signed [31:0] r_buf [MAX_WIDTH];

    logic               r_valid;
    logic               r_done;
    logic signed [31:0] r_out0;
    logic signed [31:0] r_out1;

    logic               w_accept;
    logic               w_has_room;
    logic [CNT_W-1:0]   w_fill_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic signed [31:0] w_sum_next;
    logic [CNT_W-1:0]   w_win_clip;
    logic               w_win_empty;

    assign _valid = r_valid;
    assign _done  = r_done;
    assign _out0  = r_out0;
    assign _out1  = r_out1;

    // Accept only when the output slot is free; done and start both block data.
    assign _in_ready = (r_state == StPull) && (_ready || !r_valid) && !_in_done && !_start;
    assign w_accept  = _in_valid && _in_ready;

    assign w_win_empty = (window <= 0);
    assign w_win_clip  = (window > MaxWin) ? CNT_W'(MAX_WIDTH) : window[CNT_W-1:0];

    // Window arithmetic for the item being accepted this cycle.
    always_comb begin
        w_has_room  = (r_fill < r_win);
        w_fill_next = r_fill;
        w_sum_next  = r_sum + _in0;
        if (w_has_room) begin
            w_fill_next = r_fill + CntOne;
        end else begin
            w_sum_next = r_sum + _in0 - r_buf[r_ptr];
        end
        w_ptr_next = ({1'b0, r_ptr} == (r_win - CntOne)) ? '0 : r_ptr + PtrOne;
    end

    // Next-state: termination once upstream is done and no output is stuck.
    always_comb begin
        w_state_next = r_state;
        w_term       = 1'b0;
        if ((r_state == StPull) && _in_done && (_ready || !r_valid)) begin
            w_term       = 1'b1;
            w_state_next = StDone;
        end
    end

    // State register; start beats reset.
    always_ff @(posedge _clock) begin
        if (_start) begin
            r_state <= w_win_empty ? StDone : StPull;
        end else if (_reset) begin
            r_state <= StDone;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Window bookkeeping and output register.
    always_ff @(posedge _clock) begin
        if (_start) begin
            r_win   <= w_win_clip;
            r_fill  <= '0;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= w_win_empty;
        end else if (_reset) begin
            r_fill  <= '0;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_out0  <= '0;
            r_out1  <= '0;
        end else begin
            r_done <= (r_state == StDone) || w_term;
            if (_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_fill <= w_fill_next;
                r_sum  <= w_sum_next;
                r_ptr  <= w_ptr_next;
                r_idx  <= r_idx + 32'sd1;
                if (w_fill_next == r_win) begin
                    r_out0  <= w_sum_next;
                    r_out1  <= r_idx;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // Circular item buffer; contents are only meaningful below the fill level.
    always_ff @(posedge _clock) begin
        if (w_accept && !_reset) begin
            r_buf[r_ptr] <= _in0;
        end
    end

endmodule

// File: tb/tb_window_sum.sv
// Bench for window_sum: table vectors, directed corner sequences and
// randomized streams checked against a queue-based sliding-window model.
module tb_window_sum;

    localparam int MaxW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] win;
    logic signed [31:0] in0;
    logic               in_valid;
    logic               in_done;
    logic               in_ready;
    logic               ready;
    logic               o_valid;
    logic               o_done;
    logic signed [31:0] out0;
    logic signed [31:0] out1;

    always #5 clk = ~clk;

    window_sum #(.MAX_WIDTH(MaxW)) dut (
        ._clock   (clk),
        ._reset   (rst),
        ._start   (start),
        .window   (win),
        ._in0     (in0),
        ._in_valid(in_valid),
        ._in_done (in_done),
        ._in_ready(in_ready),
        ._ready   (ready),
        ._valid   (o_valid),
        ._done    (o_done),
        ._out0    (out0),
        ._out1    (out1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [31:0] q_in [$];
    logic signed [31:0] q_es [$];
    logic signed [31:0] q_ei [$];
    logic signed [31:0] q_gs [$];
    logic signed [31:0] q_gi [$];

    typedef struct {
        logic signed [31:0] win;
        int                 n;
        logic [5:0][31:0]   items;
        int                 n_exp;
        logic [5:0][31:0]   es;
        logic [5:0][31:0]   ei;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Reference: keep the newest w items in a queue and sum them outright.
    task automatic model(input logic signed [31:0] w_in);
        logic signed [31:0] win_q [$];
        logic signed [31:0] s;
        int                 w;
        q_es.delete();
        q_ei.delete();
        w = (w_in > MaxW) ? MaxW : int'(w_in);
        if (w <= 0) return;
        foreach (q_in[k]) begin
            win_q.push_back(q_in[k]);
            if (win_q.size() > w) void'(win_q.pop_front());
            if (win_q.size() == w) begin
                s = 0;
                foreach (win_q[j]) s = s + win_q[j];
                q_es.push_back(s);
                q_ei.push_back(k);
            end
        end
    endtask

    // mode 0: ready always high; 1: random ready/valid; 2: hold ready low 3 cycles
    // on the first output. Compares collected outputs against q_es/q_ei.
    task automatic run(input string tag, input logic signed [31:0] w, input int mode,
                       input bit with_rst);
        int k         = 0;
        int hold      = 0;
        bit done_seen = 1'b0;
        q_gs.delete();
        q_gi.delete();
        start    = 1'b1;
        win      = w;
        rst      = with_rst;
        in_valid = 1'b0;
        in_done  = 1'b0;
        ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            ready = 1'b1;
            if (mode == 1) ready = ($urandom_range(0, 3) != 0);
            if (mode == 2 && o_valid && hold < 3) begin
                ready = 1'b0;
                hold++;
            end
            if (k < q_in.size()) begin
                in_done  = 1'b0;
                in0      = q_in[k];
                in_valid = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
            end else begin
                in_done  = 1'b1;
                in0      = 32'sd0;
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (mode == 2 && !ready && q_es.size() > 0) begin
                check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_bp_valid"}, 32'(o_valid), 32'd1);
                check({tag, "_bp_out0"}, out0, q_es[0]);
                check({tag, "_bp_out1"}, out1, q_ei[0]);
            end
            if (o_valid && ready) begin
                q_gs.push_back(out0);
                q_gi.push_back(out1);
            end
            if (in_valid && in_ready) k++;
            if (o_done) done_seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_out_count"}, 32'(q_gs.size()), 32'(q_es.size()));
        for (int i = 0; i < q_gs.size() && i < q_es.size(); i++) begin
            check($sformatf("%s_sum%0d", tag, i), q_gs[i], q_es[i]);
            check($sformatf("%s_idx%0d", tag, i), q_gi[i], q_ei[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'sd3, 5, {32'd0, 32'd8, 32'd6, 32'd4, 32'd2, 32'd0}, 3,
                    {32'd0, 32'd0, 32'd0, 32'd18, 32'd12, 32'd6},
                    {32'd0, 32'd0, 32'd0, 32'd4, 32'd3, 32'd2}};
        vecs[1] = '{32'sd1, 3, {32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFD, 32'd5}, 3,
                    {32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFD, 32'd5},
                    {32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0}};
        vecs[2] = '{32'sd20, 5, {32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 0,
                    '0, '0};
        vecs[3] = '{32'sd2, 2, {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}, 1,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h8000_0000},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1}};
        vecs[4] = '{-32'sd5, 2, {32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1}, 0,
                    '0, '0};

        // Reset state
        rst = 1'b1; start = 1'b0; win = 0; in0 = 0; in_valid = 1'b0; in_done = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_out0", out0, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst_done_next", 32'(o_done), 32'd1);

        // Table vectors
        for (int t = 0; t < 5; t++) begin
            q_in.delete(); q_es.delete(); q_ei.delete();
            for (int i = 0; i < vecs[t].n; i++) q_in.push_back(vecs[t].items[i]);
            for (int i = 0; i < vecs[t].n_exp; i++) begin
                q_es.push_back(vecs[t].es[i]);
                q_ei.push_back(vecs[t].ei[i]);
            end
            run($sformatf("vec%0d", t), vecs[t].win, 0, 1'b0);
        end

        // window = 0: done the cycle after start, no data accepted
        @(posedge clk); #1;
        start = 1'b1; win = 0; in_valid = 1'b1; in0 = 32'sd9; in_done = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("w0_done%0d", i), 32'(o_done), 32'd1);
            check($sformatf("w0_valid%0d", i), 32'(o_valid), 32'd0);
            check($sformatf("w0_in_ready%0d", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end

        // Backpressure
        q_in = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        model(32'sd2);
        run("bp", 32'sd2, 2, 1'b0);

        // Reset mid-stream after first output
        @(posedge clk); #1;
        start = 1'b1; win = 32'sd2; in_valid = 1'b0; in_done = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in0 = 32'sd1;
        @(posedge clk); #1;
        in0 = 32'sd2;
        @(posedge clk); #1;
        in_valid = 1'b0; ready = 1'b0;
        @(negedge clk);
        check("mid_valid_pre", 32'(o_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("mid_valid_post", 32'(o_valid), 32'd0);
        check("mid_done_post", 32'(o_done), 32'd0);
        @(negedge clk);
        check("mid_done_next", 32'(o_done), 32'd1);

        // Start and reset together, after a partially filled run
        @(posedge clk); #1;
        start = 1'b1; win = 32'sd3; in_valid = 1'b0; in_done = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in0 = 32'sd7;
        @(posedge clk); #1;
        in0 = 32'sd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q_in = '{32'sd10, 32'sd20};
        q_es = '{32'sd30};
        q_ei = '{32'sd1};
        run("strst", 32'sd2, 0, 1'b1);

        // Randomized streams
        for (int r = 0; r < 8; r++) begin
            int                 n;
            logic signed [31:0] w;
            w = $signed(32'($urandom_range(0, 13))) - 32'sd2;
            n = $urandom_range(0, 20);
            q_in.delete();
            for (int i = 0; i < n; i++) begin
                if (r % 2 == 0) q_in.push_back($urandom);
                else q_in.push_back($signed(32'($urandom_range(0, 200))) - 32'sd100);
            end
            model(w);
            run($sformatf("rnd%0d", r), w, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
